// File: rtl/teclado_uart_sched.sv
// teclado_uart_sched
// Moves PS/2 scan codes into the UART without manual triggering. Incoming
// codes are buffered in a small FIFO, with optional removal of break
// sequences (8'hF0 plus the byte after it). Each buffered byte is written to
// the UART data register, then the control register is written to start the
// send, and the scheduler waits for the UART to finish (or for an
// acknowledge timeout) plus an optional idle gap before taking the next byte.
//
// Ports:
//   clk_i, reset_i    clock, asynchronous active-high reset
//   code_valid_i      one-cycle strobe qualifying code_i
//   code_i[7:0]       scan code from the keyboard peripheral
//   flush_i           synchronous clear of FIFO, filter state and overflow flag
//   uart_busy_i       UART transmit-in-progress flag
//   uart_data_o[31:0] data bus towards the UART register file
//   uart_we_data_o    data-register write strobe
//   uart_we_ctrl_o    control-register write strobe
//   fifo_count_o      current FIFO occupancy
//   overflow_o        sticky: a code was lost because the FIFO was full
module teclado_uart_sched #(
  parameter int FIFO_DEPTH   = 8,
  parameter bit FILTER_BREAK = 1'b1,
  parameter int GAP_CYCLES   = 16,
  parameter int ACK_TIMEOUT  = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          code_valid_i,
  input  logic [7:0]                    code_i,
  input  logic                          flush_i,
  input  logic                          uart_busy_i,
  output logic [31:0]                   uart_data_o,
  output logic                          uart_we_data_o,
  output logic                          uart_we_ctrl_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          overflow_o
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int AKW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [CW-1:0]  CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
  localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0]  GAP_ONE  = GW'(1);
  localparam logic [AKW-1:0] ACK_LAST = AKW'(ACK_TIMEOUT);
  localparam logic [AKW-1:0] ACK_ONE  = AKW'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4,
    GAP       = 3'd5
  } state_t;

  // FIFO and filter state
  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           skip_q, skip_d;
  logic           overflow_q, overflow_d;

  // scheduler state
  state_t         state_q, state_d;
  logic [7:0]     byte_q, byte_d;
  logic [AKW-1:0] ack_q, ack_d;
  logic [GW-1:0]  gap_q, gap_d;

  // registered UART-side outputs
  logic [31:0]    data_q, data_d;
  logic           we_data_q, we_data_d;
  logic           we_ctrl_q, we_ctrl_d;

  logic           accept;
  logic           full;
  logic           pop;
  logic           push;
  state_t         after_tx;

  // Filter, push/pop decisions and FIFO bookkeeping.
  always_comb begin
    accept     = 1'b0;
    full       = (count_q == CNT_FULL);
    pop        = (state_q == IDLE) && (count_q != '0) && !flush_i;
    push       = 1'b0;
    skip_d     = skip_q;
    overflow_d = overflow_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    // The byte following F0 is dropped even if it is another F0.
    if (code_valid_i && !flush_i) begin
      if (FILTER_BREAK && skip_q) begin
        accept = 1'b0;
        skip_d = 1'b0;
      end else if (FILTER_BREAK && (code_i == 8'hF0)) begin
        accept = 1'b0;
        skip_d = 1'b1;
      end else begin
        accept = 1'b1;
      end
    end else begin
      accept = 1'b0;
    end

    // A full FIFO still takes a code when the head leaves in the same cycle.
    push = accept && (!full || pop);

    if (flush_i) begin
      skip_d     = 1'b0;
      overflow_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (accept && !push) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push && !pop) begin
        count_d = count_q + CNT_ONE;
      end else if (pop && !push) begin
        count_d = count_q - CNT_ONE;
      end else begin
        count_d = count_q;
      end
    end
  end

  // Scheduler next state and the values the outputs take at the next edge.
  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    ack_d    = ack_q;
    gap_d    = gap_q;
    after_tx = (GAP_CYCLES == 0) ? IDLE : GAP;

    case (state_q)
      IDLE: begin
        if (pop) begin
          byte_d  = mem_q[rd_ptr_q];
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        state_d = START;
      end
      START: begin
        ack_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (uart_busy_i) begin
          state_d = WAIT_DONE;
        end else begin
          // Busy still low: the byte counts as sent once the timeout expires.
          ack_d = ack_q + ACK_ONE;
          if (ack_d == ACK_LAST) begin
            gap_d   = '0;
            state_d = after_tx;
          end else begin
            state_d = WAIT_ACK;
          end
        end
      end
      WAIT_DONE: begin
        if (!uart_busy_i) begin
          gap_d   = '0;
          state_d = after_tx;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d   = gap_q + GAP_ONE;
          state_d = GAP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    we_data_d = (state_d == LOAD);
    we_ctrl_d = (state_d == START);
    if (state_d == LOAD) begin
      data_d = {24'h00_0000, byte_d};
    end else if (state_d == START) begin
      data_d = 32'h0000_0001;
    end else begin
      data_d = 32'h0000_0000;
    end
  end

  // Scan-code storage.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= code_i;
    end
  end

  // State, FIFO control and output registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      skip_q     <= 1'b0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      byte_q     <= 8'h00;
      ack_q      <= '0;
      gap_q      <= '0;
      data_q     <= 32'h0000_0000;
      we_data_q  <= 1'b0;
      we_ctrl_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      skip_q     <= skip_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      byte_q     <= byte_d;
      ack_q      <= ack_d;
      gap_q      <= gap_d;
      data_q     <= data_d;
      we_data_q  <= we_data_d;
      we_ctrl_q  <= we_ctrl_d;
    end
  end

  assign uart_data_o    = data_q;
  assign uart_we_data_o = we_data_q;
  assign uart_we_ctrl_o = we_ctrl_q;
  assign fifo_count_o   = count_q;
  assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_teclado_uart_sched.sv
// Directed bench for teclado_uart_sched with default parameters
// (depth 8, break filter on, 16-cycle gap, 4-cycle ack timeout).
// Expected bytes are queued when codes are driven; a monitor pops and
// compares them as the UART write strobes appear. A responder models the
// UART busy flag. Inputs change and outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_teclado_uart_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        code_valid;
  logic [7:0]  code;
  logic        flush;
  logic        busy;
  logic [31:0] data;
  logic        we_data;
  logic        we_ctrl;
  logic [3:0]  fifo_count;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  int cyc = 0;
  int ctrl_cyc = -100;
  int data_cyc = -100;
  int last_gap = 0;
  int sent = 0;
  int max_cnt = 0;
  int s0;

  logic busy_hold = 1'b0;
  logic pulse_busy = 1'b0;
  logic pulse_en = 1'b0;
  int   pulse_len = 3;

  assign busy = busy_hold | pulse_busy;

  always #5 clk = ~clk;

  teclado_uart_sched dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .code_valid_i   (code_valid),
    .code_i         (code),
    .flush_i        (flush),
    .uart_busy_i    (busy),
    .uart_data_o    (data),
    .uart_we_data_o (we_data),
    .uart_we_ctrl_o (we_ctrl),
    .fifo_count_o   (fifo_count),
    .overflow_o     (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] c);
    code = c;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    repeat (140) @(negedge clk);
  endtask

  // Monitor: scoreboard of sent bytes and per-cycle bus checks.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (32'(fifo_count) > 32'(max_cnt)) max_cnt = int'(fifo_count);
      chk("strobe_excl", 32'(we_data & we_ctrl), 32'd0);
      if (we_data) begin
        chk("send_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("send_data", data, {24'h0, e});
        end
        last_gap = cyc - ctrl_cyc;
        data_cyc = cyc;
        sent++;
      end else if (we_ctrl) begin
        chk("ctrl_data", data, 32'h1);
        chk("ctrl_after_data", 32'(cyc - data_cyc), 32'd1);
        ctrl_cyc = cyc;
      end else begin
        chk("idle_data", data, 32'h0);
      end
    end
  end

  // UART model: busy rises 2 cycles after the control write, for pulse_len cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (we_ctrl === 1'b1 && pulse_en) begin
        repeat (2) @(negedge clk);
        pulse_busy = 1'b1;
        repeat (pulse_len) @(negedge clk);
        pulse_busy = 1'b0;
      end
    end
  end

  initial begin
    reset = 1'b1;
    code_valid = 1'b0;
    code = 8'h00;
    flush = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_data", data, 32'h0);
    chk("rst_we_data", 32'(we_data), 32'd0);
    chk("rst_we_ctrl", 32'(we_ctrl), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // single byte, latency, gap after busy falls
    pulse_en = 1'b1;
    pulse_len = 100;
    exp_q.push_back(8'h1C);
    push(8'h1C);
    chk("lat_count", 32'(fifo_count), 32'd1);
    @(negedge clk);
    chk("lat_we_data", 32'(we_data), 32'd1);
    chk("lat_data", data, 32'h1C);
    @(negedge clk);
    chk("lat_we_ctrl", 32'(we_ctrl), 32'd1);
    exp_q.push_back(8'h2A);
    push(8'h2A);
    wait_drain();
    // START S, busy high S+2..S+101, low seen S+102, GAP 16, IDLE, LOAD at S+120
    chk("gap_after_busy", 32'(last_gap), 32'd120);

    // break filter: primer byte held in WAIT_DONE so the rest accumulate
    pulse_len = 3;
    busy_hold = 1'b1;
    exp_q.push_back(8'h11);
    push(8'h11);
    repeat (6) @(negedge clk);
    max_cnt = 0;
    exp_q.push_back(8'h1C);
    exp_q.push_back(8'hE0);
    exp_q.push_back(8'h75);
    push(8'h1C);
    push(8'hF0);
    push(8'h1C);
    push(8'hE0);
    push(8'h75);
    chk("filter_count", 32'(fifo_count), 32'd3);
    chk("filter_peak", 32'(max_cnt), 32'd3);
    busy_hold = 1'b0;
    wait_drain();

    // overflow: 1 in flight + 8 stored + 1 dropped
    s0 = sent;
    busy_hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) exp_q.push_back(8'h20 + 8'(i));
      push(8'h20 + 8'(i));
    end
    chk("ovf_count", 32'(fifo_count), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    busy_hold = 1'b0;
    wait_drain();
    chk("ovf_sent", 32'(sent - s0), 32'd9);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // busy stuck low: 4 WAIT_ACK cycles, 16 GAP, IDLE, LOAD at START+22
    pulse_en = 1'b0;
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    push(8'h33);
    push(8'h44);
    wait_drain();
    chk("ack_timeout_gap", 32'(last_gap), 32'd22);

    // flush with 5 stored and one byte in WAIT_DONE
    pulse_en = 1'b1;
    s0 = sent;
    busy_hold = 1'b1;
    exp_q.push_back(8'h55);
    push(8'h55);
    repeat (6) @(negedge clk);
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
    chk("pre_flush_count", 32'(fifo_count), 32'd5);
    flush = 1'b1;
    push(8'h77);
    flush = 1'b0;
    chk("flush_count", 32'(fifo_count), 32'd0);
    chk("flush_overflow", 32'(overflow), 32'd0);
    busy_hold = 1'b0;
    repeat (80) @(negedge clk);
    chk("flush_inflight_done", 32'(exp_q.size()), 32'd0);
    chk("flush_sent", 32'(sent - s0), 32'd1);
    chk("flush_count_after", 32'(fifo_count), 32'd0);

    // reset during START
    exp_q.push_back(8'h66);
    push(8'h66);
    @(negedge clk);
    @(posedge clk);
    #2;
    chk("start_we_ctrl", 32'(we_ctrl), 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_we_ctrl", 32'(we_ctrl), 32'd0);
    chk("arst_data", data, 32'h0);
    chk("arst_we_data", 32'(we_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_count", 32'(fifo_count), 32'd0);
    chk("post_rst_data", data, 32'h0);
    exp_q.push_back(8'h7E);
    push(8'h7E);
    chk("post_rst_lat_count", 32'(fifo_count), 32'd1);
    @(negedge clk);
    chk("post_rst_we_data", 32'(we_data), 32'd1);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/teclado_uart_sched.md
Name: teclado_uart_sched

Overview:
Scheduler between the PS/2 keyboard peripheral and the UART peripheral. It buffers received scan codes in a small FIFO and optionally drops break (key-release) sequences. For each buffered byte it writes the UART data register, then the UART control register. It waits for the UART to finish before sending the next byte. This replaces manual button-driven triggering of UART sends.

Parameters:
FIFO_DEPTH, 8, scan-code FIFO entries; power of two, at least 2
FILTER_BREAK, 1, when 1, discard 8'hF0 and the byte that follows it
GAP_CYCLES, 16, idle cycles inserted after each completed transmission; 0 = no gap
ACK_TIMEOUT, 4, cycles to wait for uart_busy_i to rise before the byte is treated as sent

Ports:
clk_i  input  1  system clock (10 MHz domain)
reset_i  input  1  asynchronous, active-high reset
code_valid_i  input  1  one-cycle pulse: new scan code on code_i
code_i  input  8  scan code from the keyboard peripheral
flush_i  input  1  synchronous clear of FIFO, filter state and overflow flag
uart_busy_i  input  1  high while the UART is transmitting (control send bit)
uart_data_o  output  32  data bus to the UART
uart_we_data_o  output  1  UART data-register write strobe
uart_we_ctrl_o  output  1  UART control-register write strobe
fifo_count_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow_o  output  1  sticky flag: a code was dropped because the FIFO was full

Behaviour:
- Reset (asynchronous, reset_i=1): FIFO empty, pointers 0, skip flag 0, state IDLE, gap counter 0. All outputs are 0.
- Filter:
  - Applies when FILTER_BREAK=1 and code_valid_i=1.
  - code_i=8'hF0: not stored; set skip.
  - skip=1: the code is not stored; clear skip.
  - 8'hE0 and all other codes are stored normally.
  - With FILTER_BREAK=0 every code is stored.
- Push: an accepted code is written at the rising edge of the cycle where code_valid_i=1.
  - If the FIFO is full and no pop occurs that cycle: drop the code and set overflow_o.
  - Push and pop in the same cycle while full: the push is accepted and the count is unchanged.
- FSM states: IDLE, LOAD, START, WAIT_ACK, WAIT_DONE, GAP.
  - IDLE: if count>0, pop the head into the byte register and go to LOAD. Outputs 0.
  - LOAD (1 cycle): uart_data_o={24'h0,byte}, uart_we_data_o=1. Next state START.
  - START (1 cycle): uart_data_o=32'h1, uart_we_ctrl_o=1. Clear the ack counter. Next state WAIT_ACK.
  - WAIT_ACK: if uart_busy_i=1, go to WAIT_DONE. Otherwise increment the ack counter; when it reaches ACK_TIMEOUT, go to GAP (or IDLE if GAP_CYCLES=0).
  - WAIT_DONE: when uart_busy_i=0, go to GAP (or IDLE if GAP_CYCLES=0).
  - GAP: count GAP_CYCLES cycles, then go to IDLE.
- uart_data_o is 0 in every state other than LOAD and START. The strobes are never high together.
- Latency: code_valid_i at cycle 0 with FIFO empty and FSM in IDLE gives:
  - cycle 1: count=1, pop
  - cycle 2: LOAD
  - cycle 3: START
- flush_i:
  - Clears FIFO, skip flag and overflow_o at the next edge.
  - A code_valid_i in the same cycle is discarded.
  - An in-flight byte (LOAD..GAP) completes normally.
- fifo_count_o is registered and reflects pushes and pops at each edge.
- Reset asserted mid-operation: immediate return to the reset state. Any strobe drops asynchronously.

Test Plan:
- Reset, then push 8'h1C; uart_busy_i pulses high 2 cycles after START for 100 cycles -> one write of 32'h1C with uart_we_data_o, next cycle uart_we_ctrl_o with 32'h1; the next pop occurs 16 cycles after busy falls.
- FILTER_BREAK=1, push 1C,F0,1C,E0,75 -> UART receives 1C,E0,75 in order; fifo_count_o peaks at 3.
- Hold uart_busy_i=1 and push 10 codes -> fifo_count_o reaches 8 after the first pop; overflow_o=1 after the 10th push (1 in flight + 8 stored, 1 dropped); release busy -> 9 bytes sent in order.
- uart_busy_i stuck at 0 -> after START, 4 cycles in WAIT_ACK, then GAP; the next byte proceeds without hang.
- Assert flush_i while the FIFO holds 5 codes and a byte is in WAIT_DONE -> fifo_count_o=0 and overflow_o=0; the in-flight byte completes; nothing else is sent.
- Assert reset_i during START -> uart_we_ctrl_o drops within the same cycle; all outputs 0 and state IDLE after release.
